// File: rtl/pat_code_rx.sv
// UART receiver (8N1) plus frame assembler: HEADER, hi, lo, hi^lo checksum -> Code/Fetch.
// Framing, checksum and inter-byte timeout errors are reported on a single frame_err pulse.
module pat_code_rx #(
    parameter int          CLK_FREQ     = 50000000,
    parameter int          BAUD         = 9600,
    parameter logic [7:0]  HEADER       = 8'hAA,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    output logic [15:0] Code,
    output logic        Fetch,
    output logic        frame_err,
    output logic        rx_busy
);
    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int HALF    = BIT_CNT / 2;
    localparam int TO_CYC  = TIMEOUT_BITS * BIT_CNT;
    localparam int CW      = $clog2(BIT_CNT + 1);
    localparam int TW      = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
    typedef enum logic [1:0] {A_HDR, A_HI, A_LO, A_SUM} asm_st_t;

    logic [1:0]    r_sync;
    logic [1:0]    r_prime;
    logic          r_armed;
    logic          w_rxs;
    rx_st_t        r_rx_st;
    logic [CW-1:0] r_bcnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_byte_valid;
    logic          r_rx_ferr;
    logic          w_tick;
    asm_st_t       r_asm;
    logic [7:0]    r_hi;
    logic [7:0]    r_lo;
    logic [TW-1:0] r_tcnt;
    logic          w_tout;
    logic [15:0]   r_code;
    logic          r_fetch;
    logic          r_frame_err;

    assign w_rxs  = r_sync[1];
    assign w_tick = (r_bcnt == CW'(BIT_CNT - 1));
    assign w_tout = (r_tcnt == TW'(TO_CYC));

    // The receiver arms only once the freshly loaded synchronizer shows the line idle-high,
    // so a reset released in the middle of a byte cannot start on a stale low level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_prime <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rxd};
            r_prime <= {r_prime[0], 1'b1};
            r_armed <= r_armed | (r_prime[1] & w_rxs);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_st      <= RX_IDLE;
            r_bcnt       <= '0;
            r_bit        <= '0;
            r_byte_valid <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_rx_ferr    <= 1'b0;
            case (r_rx_st)
                RX_IDLE: begin
                    r_bcnt <= '0;
                    if (r_armed && !w_rxs) r_rx_st <= RX_START;
                end
                RX_START: begin
                    if (r_bcnt == CW'(HALF - 1)) begin
                        r_bcnt  <= '0;
                        r_bit   <= '0;
                        r_rx_st <= w_rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_bcnt <= '0;
                        r_bit  <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_rx_st <= RX_STOP;
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        r_bcnt       <= '0;
                        r_rx_st      <= RX_IDLE;
                        r_byte_valid <= w_rxs;
                        r_rx_ferr    <= ~w_rxs;
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end

    // Pure data path: captured bytes need no reset value.
    always_ff @(posedge clk) begin
        if (r_rx_st == RX_DATA && w_tick) r_shift <= {w_rxs, r_shift[7:1]};
        if (r_rx_st == RX_STOP && w_tick) r_byte <= r_shift;
        if (r_byte_valid && r_asm == A_HI) r_hi <= r_byte;
        if (r_byte_valid && r_asm == A_LO) r_lo <= r_byte;
    end

    // Framing error outranks everything; a byte_valid clears the gap counter, so a
    // checksum result and a timeout can never land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm       <= A_HDR;
            r_tcnt      <= '0;
            r_code      <= 16'h0000;
            r_fetch     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_fetch     <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_asm == A_HDR || r_rx_st != RX_IDLE || r_byte_valid) r_tcnt <= '0;
            else if (!w_tout) r_tcnt <= r_tcnt + 1'b1;

            if (r_rx_ferr) begin
                r_asm       <= A_HDR;
                r_frame_err <= 1'b1;
            end else if (r_byte_valid) begin
                case (r_asm)
                    A_HDR: if (r_byte == HEADER) r_asm <= A_HI;
                    A_HI:  r_asm <= A_LO;
                    A_LO:  r_asm <= A_SUM;
                    A_SUM: begin
                        r_asm <= A_HDR;
                        if (r_byte == (r_hi ^ r_lo)) begin
                            r_code  <= {r_hi, r_lo};
                            r_fetch <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: r_asm <= A_HDR;
                endcase
            end else if (r_asm != A_HDR && w_tout) begin
                r_asm       <= A_HDR;
                r_frame_err <= 1'b1;
            end
        end
    end

    assign Code      = r_code;
    assign Fetch     = r_fetch;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_asm != A_HDR);
endmodule

// File: tb/tb_pat_code_rx.sv
// Bench for pat_code_rx: directed frames plus random frames against a byte-level frame model.
module tb_pat_code_rx;
    localparam int BC  = 16;
    localparam int TO  = 4 * BC;
    // sync (2) + idle detect (1) + half bit + 9 bit times to stop sample + byte_valid + register
    localparam int LAT = 3 + BC / 2 + 9 * BC + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic [15:0] Code;
    logic        Fetch;
    logic        frame_err;
    logic        rx_busy;

    pat_code_rx #(.CLK_FREQ(1600), .BAUD(100), .HEADER(8'hAA), .TIMEOUT_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd),
        .Code(Code), .Fetch(Fetch), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          mon_fetch = 0, mon_err = 0, viol = 0, last_fetch = 0;
    logic [15:0] prev_code = 16'h0000;
    always @(negedge clk) begin
        if (rst_n) begin
            if (Fetch) begin
                mon_fetch  <= mon_fetch + 1;
                last_fetch <= cyc;
            end
            if (frame_err) mon_err <= mon_err + 1;
            if ((Fetch && frame_err) || (Code !== prev_code && !Fetch)) viol <= viol + 1;
        end
        prev_code <= Code;
    end

    // Reference model: operates on whole received bytes and frame-level events.
    int          m_pos = 0, m_fetch = 0, m_err = 0;
    logic [7:0]  m_hi, m_lo;
    logic [15:0] m_code = 16'h0000;

    task automatic m_byte(input logic [7:0] b);
        case (m_pos)
            0: if (b == 8'hAA) m_pos = 1;
            1: begin m_hi = b; m_pos = 2; end
            2: begin m_lo = b; m_pos = 3; end
            default: begin
                if (b == (m_hi ^ m_lo)) begin m_code = {m_hi, m_lo}; m_fetch++; end
                else m_err++;
                m_pos = 0;
            end
        endcase
    endtask

    task automatic m_abort();
        m_err++;
        m_pos = 0;
    endtask

    int n_checks = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    int t_start = 0;
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk); #1; rxd = 1'b0; t_start = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (BC) @(posedge clk); #1; rxd = b[i];
        end
        repeat (BC) @(posedge clk); #1; rxd = stop;
        repeat (BC) @(posedge clk); #1; rxd = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
        m_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        if (n >= TO && m_pos != 0) m_abort();
    endtask

    task automatic chk_state(input string tag);
        @(negedge clk);
        chk({tag, "_fetch"}, 32'(mon_fetch), 32'(m_fetch));
        chk({tag, "_err"},   32'(mon_err),   32'(m_err));
        chk({tag, "_code"},  32'(Code),      32'(m_code));
    endtask

    initial begin
        logic [7:0] hi, lo, sum, junk;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_code", 32'(Code), 32'h0);
        chk("rst_fetch", 32'(Fetch), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(rx_busy), 32'h0);
        rst_n = 1'b1;
        idle(10);

        send(8'hAA); send(8'h12); send(8'h34); send(8'h26);
        chk("valid_lat", 32'(last_fetch - t_start), 32'(LAT));
        idle(20);
        chk_state("valid");

        send(8'hAA); send(8'h12); send(8'h34); send(8'h00);
        idle(5);
        chk("badsum_busy", 32'(rx_busy), 32'h0);
        chk_state("badsum");

        send(8'h55); send(8'hAA); send(8'h00); send(8'hFF); send(8'hFF);
        idle(20);
        chk_state("garbage");

        @(posedge clk); #1; rxd = 1'b0;
        repeat (4) @(posedge clk); #1; rxd = 1'b1;
        idle(40);
        chk_state("glitch");

        send_byte(8'hAA, 1'b0);
        m_abort();
        idle(20);
        chk("ferr_busy", 32'(rx_busy), 32'h0);
        chk_state("ferr");

        send(8'hAA); send(8'h12);
        chk("to_busy_mid", 32'(rx_busy), 32'h1);
        idle(TO + 40);
        chk("to_busy", 32'(rx_busy), 32'h0);
        chk_state("timeout");
        send(8'hAA); send(8'hAB); send(8'hCD); send(8'h66);
        idle(20);
        chk_state("after_to");

        for (int k = 0; k < 10; k++) begin
            hi = 8'($urandom); lo = 8'($urandom); junk = 8'($urandom);
            sum = (($urandom_range(3) == 0) ? (hi ^ lo ^ 8'h5A) : (hi ^ lo));
            if ($urandom_range(3) == 0) send(junk);
            send(8'hAA); send(hi); send(lo); send(sum);
            idle(TO + 20);
            chk_state("rand");
        end

        send(8'hAA); send(8'h77); send(8'h01); send(8'h76);
        send(8'hAA); send(8'h12);
        @(posedge clk); #1; rxd = 1'b0;
        repeat (40) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        chk("mid_rst_code", 32'(Code), 32'h0);
        chk("mid_rst_fetch", 32'(Fetch), 32'h0);
        chk("mid_rst_busy", 32'(rx_busy), 32'h0);
        rxd = 1'b1;
        m_pos = 0; m_code = 16'h0000;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b1;
        idle(200);
        chk_state("post_rst_quiet");
        send(8'hAA); send(8'h12); send(8'h34); send(8'h26);
        idle(20);
        chk_state("post_rst_frame");

        chk("violations", 32'(viol), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
